// File: rtl/regfile_scoreboard.sv
// Integer register file with registered multi-port reads, optional write bypass,
// and a per-register busy scoreboard used by decode to stall on pending producers.
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0]        regs_q [DEPTH];
    logic [DEPTH-1:0]         busy_q, busy_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;
    logic [CNT_W-1:0]         busy_cnt_q, busy_cnt_d;
    logic [ADDR_W-1:0]        rd_idx [NUM_RD];
    logic                     wr_zero;
    logic                     wr_ok;

    assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
    assign wr_ok   = wr_en && !wr_zero;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_idx
        assign rd_idx[k] = rd_addr[k*ADDR_W +: ADDR_W];
    end

    // Issue beats completion on the same register: the new producer still owes a result.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wr_en) begin
                busy_d[wr_addr] = 1'b0;
            end
            if (iss_en) begin
                busy_d[iss_addr] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int r = 0; r < DEPTH; r++) begin
            busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[r]);
        end
    end

    // Busy flags come from the next-state so they line up with the data captured this edge.
    always_comb begin
        rd_data_d = '0;
        rd_busy_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if ((ZERO_REG != 0) && (rd_idx[k] == '0)) begin
                rd_data_d[k*DATA_W +: DATA_W] = '0;
            end else if ((BYPASS != 0) && wr_ok && (wr_addr == rd_idx[k])) begin
                rd_data_d[k*DATA_W +: DATA_W] = wr_data;
            end else begin
                rd_data_d[k*DATA_W +: DATA_W] = regs_q[rd_idx[k]];
            end
            rd_busy_d[k] = busy_d[rd_idx[k]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            rd_data_q  <= '0;
            rd_busy_q  <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_busy_q  <= rd_busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_busy  = rd_busy_q;
    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios with literal expectations plus
// a randomized run, all checked every cycle against an array-based reference model.
module tb_regfile_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;

    logic                     clk;
    logic                     rst;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     flush;
    logic [ADDR_W:0]          busy_cnt;

    regfile_scoreboard #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .BYPASS   (1),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DATA_W-1:0] m_regs [DEPTH];
    bit                m_busy [DEPTH];
    logic [DATA_W-1:0] e_data [NUM_RD];
    bit                e_busy [NUM_RD];
    int                e_cnt;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Expected outputs from the architectural rules, using pre-edge model state.
    task automatic model_step(input bit r, input bit we, input int wa, input logic [31:0] wd,
                              input int ra0, input int ra1, input bit ie, input int ia,
                              input bit fl);
        int ra [NUM_RD];
        bit nb [DEPTH];
        ra[0] = ra0;
        ra[1] = ra1;
        if (r) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 0;
            end
            for (int k = 0; k < NUM_RD; k++) begin
                e_data[k] = '0;
                e_busy[k] = 0;
            end
            e_cnt = 0;
            return;
        end
        for (int i = 0; i < DEPTH; i++) nb[i] = m_busy[i];
        if (fl) begin
            for (int i = 0; i < DEPTH; i++) nb[i] = 0;
        end else begin
            if (we) nb[wa] = 0;
            if (ie) nb[ia] = 1;
        end
        nb[0] = 0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (ra[k] == 0)                      e_data[k] = '0;
            else if (we && wa == ra[k])          e_data[k] = wd;
            else                                 e_data[k] = m_regs[ra[k]];
            e_busy[k] = nb[ra[k]];
        end
        if (we && wa != 0) m_regs[wa] = wd;
        e_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_busy[i] = nb[i];
            e_cnt += int'(nb[i]);
        end
    endtask

    task automatic cyc(input bit r, input bit we, input int wa, input logic [31:0] wd,
                       input int ra0, input int ra1, input bit ie, input int ia, input bit fl);
        rst      = r;
        wr_en    = we;
        wr_addr  = ADDR_W'(wa);
        wr_data  = wd;
        rd_addr  = {ADDR_W'(ra1), ADDR_W'(ra0)};
        iss_en   = ie;
        iss_addr = ADDR_W'(ia);
        flush    = fl;
        model_step(r, we, wa, wd, ra0, ra1, ie, ia, fl);
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_RD; k++) begin
            check($sformatf("model rd_data[%0d]", k), rd_data[k*DATA_W +: DATA_W], e_data[k]);
            check($sformatf("model rd_busy[%0d]", k), 32'(rd_busy[k]), 32'(e_busy[k]));
        end
        check("model busy_cnt", 32'(busy_cnt), 32'(e_cnt));
    endtask

    task automatic idle(input int ra0, input int ra1);
        cyc(0, 0, 0, 0, ra0, ra1, 0, 0, 0);
    endtask

    initial begin
        rst = 1; wr_en = 0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        iss_en = 0; iss_addr = '0; flush = 0;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset busy_cnt", 32'(busy_cnt), 32'd0);

        // Random writes and issues, then a two-cycle reset must wipe everything.
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, $urandom_range(31), $urandom, $urandom_range(31), $urandom_range(31),
                1, $urandom_range(31), 0);
        end
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i += 2) begin
            idle(i, i + 1);
            check("post-reset rd_data0", rd_data[31:0], 32'h0);
            check("post-reset rd_data1", rd_data[63:32], 32'h0);
            check("post-reset rd_busy", 32'(rd_busy), 32'h0);
            check("post-reset busy_cnt", 32'(busy_cnt), 32'h0);
        end

        // Write then read one cycle later on both ports
        cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        idle(5, 5);
        check("x5 port0", rd_data[31:0], 32'hDEADBEEF);
        check("x5 port1", rd_data[63:32], 32'hDEADBEEF);

        // Same-edge write bypass
        cyc(0, 1, 7, 32'h11, 0, 0, 0, 0, 0);
        cyc(0, 1, 7, 32'h22, 7, 7, 0, 0, 0);
        check("bypass port0", rd_data[31:0], 32'h22);
        check("bypass port1", rd_data[63:32], 32'h22);
        idle(7, 0);
        check("x7 stored", rd_data[31:0], 32'h22);

        // Register zero ignores writes and issue marks
        cyc(0, 1, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0);
        idle(0, 0);
        check("x0 data", rd_data[31:0], 32'h0);
        check("x0 busy", 32'(rd_busy), 32'h0);
        check("x0 busy_cnt", 32'(busy_cnt), 32'h0);

        // Scoreboard set/clear
        cyc(0, 0, 0, 0, 0, 0, 1, 3, 0);
        check("iss x3 cnt", 32'(busy_cnt), 32'd1);
        cyc(0, 0, 0, 0, 3, 0, 1, 9, 0);
        check("iss x9 cnt", 32'(busy_cnt), 32'd2);
        check("x3 rd_busy", 32'(rd_busy[0]), 32'd1);
        cyc(0, 1, 3, 32'h33, 3, 3, 0, 0, 0);
        check("wr x3 cnt", 32'(busy_cnt), 32'd1);
        check("wr x3 rd_busy", 32'(rd_busy[0]), 32'd0);
        cyc(0, 1, 9, 32'h99, 9, 0, 1, 9, 0);
        check("reissue x9 busy", 32'(rd_busy[0]), 32'd1);
        check("reissue x9 cnt", 32'(busy_cnt), 32'd1);

        // Flush beats a same-edge issue
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 2, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 4, 0);
        check("pre-flush cnt", 32'(busy_cnt), 32'd4);
        cyc(0, 0, 0, 0, 6, 0, 1, 6, 1);
        check("flush cnt", 32'(busy_cnt), 32'd0);
        check("flush x6 busy", 32'(rd_busy[0]), 32'd0);

        // Reset beats a same-edge write
        cyc(0, 0, 0, 0, 0, 0, 1, 8, 0);
        cyc(1, 1, 8, 32'hCAFEF00D, 8, 8, 0, 0, 0);
        idle(8, 3);
        check("rst x8 data", rd_data[31:0], 32'h0);
        check("rst x3 data", rd_data[63:32], 32'h0);
        check("rst cnt", 32'(busy_cnt), 32'd0);

        // Randomized traffic; small address range raises collisions
        for (int i = 0; i < 3000; i++) begin
            int rng;
            rng = ($urandom_range(3) == 0) ? 31 : 7;
            cyc(($urandom_range(199) == 0), ($urandom_range(1) == 1), $urandom_range(rng),
                $urandom, $urandom_range(rng), $urandom_range(rng),
                ($urandom_range(2) != 0), $urandom_range(rng), ($urandom_range(49) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
